// File: rtl/sid_control_multi_if.sv
// sid_control_multi_if: SID bus side of the multi-chip control block
interface sid_control_multi_if #(
    parameter int NUM_SIDS = 2
);
    logic                bus_res;
    logic [4:0]          bus_addr;
    logic [7:0]          bus_data;
    logic                bus_phi2;
    logic                bus_r_w_n;
    logic [NUM_SIDS-1:0] cs;
    logic [7:0]          data_o;

    modport master (
        output bus_res, bus_addr, bus_data, bus_phi2, bus_r_w_n, cs,
        input  data_o
    );

    modport slave (
        input  bus_res, bus_addr, bus_data, bus_phi2, bus_r_w_n, cs,
        output data_o
    );
endinterface

// File: rtl/sid_control_multi.sv
// sid_control_multi: time-multiplexed voice/filter registers for several SID chips,
// with per-chip data-bus fade and lowest-select readback arbitration
module sid_control_multi #(
    parameter int NUM_SIDS    = 2,
    parameter int VOICES      = 3,
    parameter int TTL_MOS6581 = 7,
    parameter int TTL_MOS8580 = 664,
    parameter int AGE_W       = 10,
    parameter int NV          = NUM_SIDS * VOICES,
    parameter int CW          = $clog2(2 * NV + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick_ms,
    input  logic [CW-1:0]          voice_cycle,
    input  logic [NUM_SIDS-1:0]    model,
    input  logic [32*NUM_SIDS-1:0] misc_i,
    sid_control_multi_if.slave     bus,
    output logic [55:0]            voice_o,
    output logic [$clog2(NV)-1:0]  voice_idx_o,
    output logic [31:0]            filter_o
);
    localparam int IW = $clog2(NV);

    logic [55:0]      r_voice [NV];
    logic [31:0]      r_filt  [NUM_SIDS];
    logic [7:0]       r_dval  [NUM_SIDS];
    logic [AGE_W-1:0] r_age   [NUM_SIDS];

    int          w_k, w_slot, w_chip, w_vj, w_byte, w_fbyte, w_rbyte, w_s;
    logic        w_wr, w_rd, w_run, w_commit, w_ftake, w_sel;
    logic [55:0] w_cur, w_new;
    logic [31:0] w_fcur, w_fnew;
    logic [7:0]  w_sdval;

    // Slots 1..NV commit writes, NV+1..2*NV replay the same voices read-only
    always_comb begin
        w_k      = int'(voice_cycle);
        w_run    = w_k >= 1 && w_k <= 2 * NV;
        w_commit = w_k >= 1 && w_k <= NV;
        w_slot   = w_k > NV ? w_k - 1 - NV : w_k - 1;
        w_chip   = w_slot / VOICES;
        w_vj     = w_slot % VOICES;
        w_ftake  = w_commit && w_vj == 0;
        w_byte   = int'(bus.bus_addr) - 7 * w_vj;
        w_fbyte  = int'(bus.bus_addr) - 21;
        w_rbyte  = int'(bus.bus_addr) - 25;
        w_wr     = !bus.bus_phi2 && !bus.bus_r_w_n;
        w_rd     = bus.bus_phi2 && bus.bus_r_w_n && w_rbyte >= 0 && w_rbyte <= 3;
        w_sel    = w_commit && w_wr && |(bus.cs & (NUM_SIDS'(1) << w_chip));
        w_cur    = '0;
        w_fcur   = '0;
        for (int v = 0; v < NV; v++) w_cur = v == w_slot ? r_voice[v] : w_cur;
        for (int c = 0; c < NUM_SIDS; c++) w_fcur = c == w_chip ? r_filt[c] : w_fcur;
        w_new  = w_cur;
        w_fnew = w_fcur;
        for (int b = 0; b < 7; b++)
            if (w_commit && (bus.bus_res || (w_sel && w_byte == b)))
                w_new[55-8*b -: 8] = bus.bus_res ? 8'h00 : bus.bus_data;
        for (int b = 0; b < 4; b++)
            if (w_ftake && (bus.bus_res || (w_sel && w_fbyte == b)))
                w_fnew[31-8*b -: 8] = bus.bus_res ? 8'h00 : bus.bus_data;
        w_s = 0;
        for (int i = NUM_SIDS - 1; i >= 0; i--) w_s = bus.cs[i] ? i : w_s;
        w_sdval = '0;
        for (int i = 0; i < NUM_SIDS; i++) w_sdval = i == w_s ? r_dval[i] : w_sdval;
    end

    assign bus.data_o = rst ? 8'h00 :
                        (|bus.cs && w_rd) ? 8'(misc_i >> (32 * w_s + 8 * w_rbyte)) : w_sdval;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NV; v++) r_voice[v] <= '0;
            for (int c = 0; c < NUM_SIDS; c++) r_filt[c] <= '0;
            voice_o     <= '0;
            voice_idx_o <= '0;
            filter_o    <= '0;
        end else if (w_run) begin
            for (int v = 0; v < NV; v++) if (w_commit && v == w_slot) r_voice[v] <= w_new;
            for (int c = 0; c < NUM_SIDS; c++) if (w_ftake && c == w_chip) r_filt[c] <= w_fnew;
            voice_o     <= w_new;
            voice_idx_o <= IW'(w_slot);
            if (w_vj == 0) filter_o <= w_fnew;
        end
    end

    // Age saturates at the model TTL; a later model change is seen at the next compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SIDS; i++) begin
                r_dval[i] <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SIDS; i++) begin
                if (bus.bus_res) begin
                    r_dval[i] <= '0;
                    r_age[i]  <= '0;
                end else if (bus.cs[i] && (w_wr || w_rd)) begin
                    r_dval[i] <= w_rd ? 8'(misc_i >> (32 * i + 8 * w_rbyte)) : bus.bus_data;
                    r_age[i]  <= '0;
                end else if (r_age[i] == (model[i] ? AGE_W'(TTL_MOS8580) : AGE_W'(TTL_MOS6581))) begin
                    r_dval[i] <= '0;
                end else if (voice_cycle == CW'(1)) begin
                    r_age[i] <= r_age[i] + AGE_W'(tick_ms);
                end
            end
        end
    end
endmodule
